// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache (8 lines x 4 bytes)
// with its miss-handling FSM sitting between the CPU and block-wide memory.
module dcache_controller #(
  parameter int unsigned INDEX_W  = 3,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              READ,
  input  logic                              WRITE,
  input  logic [ADDR_W-1:0]                 ADDRESS,
  input  logic [7:0]                        WRITEDATA,
  output logic [7:0]                        READDATA,
  output logic                              BUSYWAIT,
  output logic                              MEM_READ,
  output logic                              MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0]        MEM_ADDRESS,
  output logic [(8*(2**OFFSET_W))-1:0]      MEM_WRITEDATA,
  input  logic [(8*(2**OFFSET_W))-1:0]      MEM_READDATA,
  input  logic                              MEM_BUSYWAIT
);

  localparam int unsigned TagW   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned Lines  = 2 ** INDEX_W;
  localparam int unsigned BlockW = 8 * (2 ** OFFSET_W);

  typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StAllocate} state_e;

  state_e                  state_q;
  logic [BlockW-1:0]       data_q [Lines];
  logic [TagW-1:0]         tag_q  [Lines];
  logic [Lines-1:0]        valid_q;
  logic [Lines-1:0]        dirty_q;
  logic [TagW-1:0]         req_tag_q;
  logic [INDEX_W-1:0]      req_index_q;
  logic [BlockW-1:0]       fetched_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [TagW+INDEX_W-1:0] mem_addr_q;
  logic [BlockW-1:0]       mem_wdata_q;

  logic [TagW-1:0]         addr_tag;
  logic [INDEX_W-1:0]      addr_index;
  logic [OFFSET_W-1:0]     addr_offset;
  logic                    hit;
  logic                    req;
  logic                    idle;

  // Address split, hit detection, stall and zero-latency read path.
  always_comb begin
    addr_tag    = ADDRESS[ADDR_W-1 -: TagW];
    addr_index  = ADDRESS[OFFSET_W +: INDEX_W];
    addr_offset = ADDRESS[OFFSET_W-1:0];
    hit         = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
    req         = READ | WRITE;
    idle        = (state_q == StIdle);
    BUSYWAIT    = req & ~(idle & hit);
    READDATA    = data_q[addr_index][{addr_offset, 3'b000} +: 8];
  end

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

  // Miss FSM with registered memory strobes, address and victim data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && !hit) begin
            // Latch the missing line so a dropped request still completes cleanly.
            req_tag_q   <= addr_tag;
            req_index_q <= addr_index;
            if (valid_q[addr_index] && dirty_q[addr_index]) begin
              state_q     <= StWriteback;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[addr_index], addr_index};
              mem_wdata_q <= data_q[addr_index];
            end else begin
              state_q    <= StFetch;
              mem_read_q <= 1'b1;
              mem_addr_q <= {addr_tag, addr_index};
            end
          end else if (WRITE && hit) begin
            dirty_q[addr_index] <= 1'b1;
          end
        end
        StWriteback: begin
          if (!MEM_BUSYWAIT) begin
            state_q     <= StFetch;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {req_tag_q, req_index_q};
          end
        end
        StFetch: begin
          if (!MEM_BUSYWAIT) begin
            state_q    <= StAllocate;
            mem_read_q <= 1'b0;
            fetched_q  <= MEM_READDATA;
          end
        end
        StAllocate: begin
          state_q              <= StIdle;
          valid_q[req_index_q] <= 1'b1;
          dirty_q[req_index_q] <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Data and tag arrays: line fill on allocate, single-byte store on a write hit.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state_q == StAllocate) begin
        data_q[req_index_q] <= fetched_q;
        tag_q[req_index_q]  <= req_tag_q;
      end else if (idle && WRITE && hit) begin
        data_q[addr_index][{addr_offset, 3'b000} +: 8] <= WRITEDATA;
      end
    end
  end

endmodule
